// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Hazard and trap sequencer for the 5-stage RV32I pipeline. It resolves
//   load-use and memory-busy stalls and branch redirects. It also sequences
//   trap entry (ILLEGAL/ECALL/EBREAK) and trap return (MRET):
//   RUN -> DRAIN -> REDIRECT -> RUN.
//
// Ports
//   h_clk, h_rst            clock, synchronous active-low reset
//   h_i_d_*                 decode stage: valid, pc, rs1/rs2, rs2-used, exceptions
//                           (exception bits: 0 ILLEGAL, 1 ECALL, 2 EBREAK, 3 MRET)
//   h_i_ex_*                execute stage: valid, load, rd, redirect, target
//   h_i_mem_busy            memory stage waiting on the data bus
//   h_o_stall_f/d/e         hold fetch / decode / execute
//   h_o_flush_d/e           bubble decode / execute output
//   h_o_redirect            fetch loads h_o_pc_target on the next edge
//   h_o_pc_target           redirect address (0 when no redirect)
//   h_o_mepc, h_o_cause     saved trap PC and cause (registered)
//   h_o_in_trap             set by trap entry, cleared by MRET (registered)
module hazard_ctrl #(
  parameter int                   AWIDTH       = 5,
  parameter int                   PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0]  TRAP_VECTOR  = 32'h0000_0004,
  parameter int                   DRAIN_CYCLES = 2
) (
  input  logic                h_clk,
  input  logic                h_rst,
  input  logic                h_i_d_ce,
  input  logic [PC_WIDTH-1:0] h_i_d_pc,
  input  logic [AWIDTH-1:0]   h_i_d_rs1,
  input  logic [AWIDTH-1:0]   h_i_d_rs2,
  input  logic                h_i_d_use_rs2,
  input  logic [3:0]          h_i_d_exception,
  input  logic                h_i_ex_ce,
  input  logic                h_i_ex_load,
  input  logic [AWIDTH-1:0]   h_i_ex_rd,
  input  logic                h_i_ex_redirect,
  input  logic [PC_WIDTH-1:0] h_i_ex_target,
  input  logic                h_i_mem_busy,
  output logic                h_o_stall_f,
  output logic                h_o_stall_d,
  output logic                h_o_stall_e,
  output logic                h_o_flush_d,
  output logic                h_o_flush_e,
  output logic                h_o_redirect,
  output logic [PC_WIDTH-1:0] h_o_pc_target,
  output logic [PC_WIDTH-1:0] h_o_mepc,
  output logic [1:0]          h_o_cause,
  output logic                h_o_in_trap
);

  // Counter only ever holds DRAIN_CYCLES-1 down to 0.
  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_REDIRECT
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mret_pend_q, mret_pend_d;
  logic [PC_WIDTH-1:0] mepc_q, mepc_d;
  logic [1:0]          cause_q, cause_d;
  logic                in_trap_q, in_trap_d;

  logic br_take;
  logic exc_take;
  logic mret_only;
  logic load_use;

  // Cause priority ILLEGAL > ECALL > EBREAK; a pure MRET keeps the old cause.
  function automatic logic [1:0] trap_cause(input logic [3:0] exc,
                                            input logic [1:0] cur);
    if (exc[0])      return 2'd0;
    else if (exc[1]) return 2'd1;
    else if (exc[2]) return 2'd2;
    else             return cur;
  endfunction

  assign br_take   = h_i_ex_redirect && h_i_ex_ce;
  assign exc_take  = h_i_d_ce && (|h_i_d_exception);
  // MRET combined with a real trap source is handled as that trap.
  assign mret_only = (h_i_d_exception == 4'b1000);
  assign load_use  = h_i_ex_ce && h_i_ex_load && (h_i_ex_rd != '0) && h_i_d_ce &&
                     ((h_i_ex_rd == h_i_d_rs1) ||
                      (h_i_d_use_rs2 && (h_i_ex_rd == h_i_d_rs2)));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mret_pend_d   = mret_pend_q;
    mepc_d        = mepc_q;
    cause_d       = cause_q;
    in_trap_d     = in_trap_q;
    h_o_stall_f   = 1'b0;
    h_o_stall_d   = 1'b0;
    h_o_stall_e   = 1'b0;
    h_o_flush_d   = 1'b0;
    h_o_flush_e   = 1'b0;
    h_o_redirect  = 1'b0;
    h_o_pc_target = '0;

    unique case (state_q)
      ST_RUN: begin
        if (br_take) begin
          // Decode exception on the wrong path is dropped with the flush.
          h_o_redirect  = 1'b1;
          h_o_pc_target = h_i_ex_target;
          h_o_flush_d   = 1'b1;
          h_o_flush_e   = 1'b1;
        end else if (exc_take) begin
          if (!mret_only) mepc_d = h_i_d_pc;
          cause_d     = trap_cause(h_i_d_exception, cause_q);
          mret_pend_d = mret_only;
          cnt_d       = DRAIN_LOAD;
          h_o_flush_d = 1'b1;
          h_o_stall_f = 1'b1;
          state_d     = ST_DRAIN;
        end else if (h_i_mem_busy) begin
          h_o_stall_f = 1'b1;
          h_o_stall_d = 1'b1;
          h_o_stall_e = 1'b1;
        end else if (load_use) begin
          h_o_stall_f = 1'b1;
          h_o_stall_d = 1'b1;
          h_o_flush_e = 1'b1;
        end
      end

      ST_DRAIN: begin
        // Execute-stage redirects here belong to younger instructions.
        h_o_stall_f = 1'b1;
        h_o_flush_d = 1'b1;
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        if ((cnt_q == '0) && !h_i_mem_busy) state_d = ST_REDIRECT;
      end

      ST_REDIRECT: begin
        h_o_redirect  = 1'b1;
        h_o_flush_d   = 1'b1;
        h_o_flush_e   = 1'b1;
        h_o_pc_target = mret_pend_q ? mepc_q : TRAP_VECTOR;
        in_trap_d     = !mret_pend_q;
        mret_pend_d   = 1'b0;
        state_d       = ST_RUN;
      end

      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge h_clk) begin
    if (!h_rst) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      mret_pend_q <= 1'b0;
      mepc_q      <= '0;
      cause_q     <= 2'd0;
      in_trap_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mret_pend_q <= mret_pend_d;
      mepc_q      <= mepc_d;
      cause_q     <= cause_d;
      in_trap_q   <= in_trap_d;
    end
  end

  assign h_o_mepc    = mepc_q;
  assign h_o_cause   = cause_q;
  assign h_o_in_trap = in_trap_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
//   Directed scenarios plus randomized traffic for hazard_ctrl. The reference
//   model tracks a trap as "cycles elapsed since the exception" instead of a
//   down-counter and derives every output from the priority rules.
module tb_hazard_ctrl;
  localparam int          AW = 5;
  localparam int          PW = 32;
  localparam int          DC = 2;
  localparam logic [31:0] TV = 32'h0000_0004;

  logic          h_clk = 1'b0;
  logic          h_rst;
  logic          d_ce, d_use_rs2, ex_ce, ex_load, ex_redirect, mem_busy;
  logic [PW-1:0] d_pc, ex_target;
  logic [AW-1:0] d_rs1, d_rs2, ex_rd;
  logic [3:0]    d_exc;
  logic          stall_f, stall_d, stall_e, flush_d, flush_e, redirect, in_trap;
  logic [PW-1:0] pc_target, mepc;
  logic [1:0]    cause;

  always #5 h_clk = ~h_clk;

  hazard_ctrl #(.AWIDTH(AW), .PC_WIDTH(PW), .TRAP_VECTOR(TV), .DRAIN_CYCLES(DC)) dut (
    .h_clk(h_clk), .h_rst(h_rst),
    .h_i_d_ce(d_ce), .h_i_d_pc(d_pc), .h_i_d_rs1(d_rs1), .h_i_d_rs2(d_rs2),
    .h_i_d_use_rs2(d_use_rs2), .h_i_d_exception(d_exc),
    .h_i_ex_ce(ex_ce), .h_i_ex_load(ex_load), .h_i_ex_rd(ex_rd),
    .h_i_ex_redirect(ex_redirect), .h_i_ex_target(ex_target),
    .h_i_mem_busy(mem_busy),
    .h_o_stall_f(stall_f), .h_o_stall_d(stall_d), .h_o_stall_e(stall_e),
    .h_o_flush_d(flush_d), .h_o_flush_e(flush_e), .h_o_redirect(redirect),
    .h_o_pc_target(pc_target), .h_o_mepc(mepc), .h_o_cause(cause),
    .h_o_in_trap(in_trap)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model state
  bit          m_active;   // between exception and redirect
  int          m_elapsed;  // cycles spent draining so far
  bit          m_redir;    // this cycle is the trap redirect
  bit          m_ret;      // pending trap is an MRET
  logic [31:0] m_mepc;
  logic [1:0]  m_cause;
  bit          m_in_trap;

  task automatic idle();
    d_ce = 0; d_pc = '0; d_rs1 = '0; d_rs2 = '0; d_use_rs2 = 0; d_exc = '0;
    ex_ce = 0; ex_load = 0; ex_rd = '0; ex_redirect = 0; ex_target = '0;
    mem_busy = 0;
  endtask

  // Check all outputs against the model mid-cycle, then advance one edge.
  task automatic cycle();
    bit br, exc, ret_only, lu;
    bit e_sf, e_sd, e_se, e_fd, e_fe, e_rd;
    logic [31:0] e_pt;
    br       = ex_redirect && ex_ce;
    exc      = d_ce && (d_exc != 0);
    ret_only = (d_exc == 4'b1000);
    lu       = ex_ce && ex_load && (ex_rd != 0) && d_ce &&
               (ex_rd == d_rs1 || (d_use_rs2 && ex_rd == d_rs2));
    {e_sf, e_sd, e_se, e_fd, e_fe, e_rd} = '0;
    e_pt = '0;
    if (m_redir) begin
      e_rd = 1; e_fd = 1; e_fe = 1; e_pt = m_ret ? m_mepc : TV;
    end else if (m_active) begin
      e_sf = 1; e_fd = 1;
    end else if (br) begin
      e_rd = 1; e_fd = 1; e_fe = 1; e_pt = ex_target;
    end else if (exc) begin
      e_sf = 1; e_fd = 1;
    end else if (mem_busy) begin
      e_sf = 1; e_sd = 1; e_se = 1;
    end else if (lu) begin
      e_sf = 1; e_sd = 1; e_fe = 1;
    end
    #2;
    chk("stall_f", 32'(stall_f), 32'(e_sf));
    chk("stall_d", 32'(stall_d), 32'(e_sd));
    chk("stall_e", 32'(stall_e), 32'(e_se));
    chk("flush_d", 32'(flush_d), 32'(e_fd));
    chk("flush_e", 32'(flush_e), 32'(e_fe));
    chk("redirect", 32'(redirect), 32'(e_rd));
    chk("pc_target", pc_target, e_pt);
    chk("mepc", mepc, m_mepc);
    chk("cause", 32'(cause), 32'(m_cause));
    chk("in_trap", 32'(in_trap), 32'(m_in_trap));
    // model update for the coming edge
    if (!h_rst) begin
      m_active = 0; m_elapsed = 0; m_redir = 0; m_ret = 0;
      m_mepc = '0; m_cause = '0; m_in_trap = 0;
    end else if (m_redir) begin
      m_in_trap = !m_ret; m_redir = 0; m_ret = 0;
    end else if (m_active) begin
      m_elapsed++;
      if (m_elapsed >= DC && !mem_busy) begin
        m_active = 0; m_redir = 1;
      end
    end else if (!br && exc) begin
      m_active = 1; m_elapsed = 0; m_ret = ret_only;
      if (!ret_only) m_mepc = d_pc;
      if (d_exc[0])      m_cause = 2'd0;
      else if (d_exc[1]) m_cause = 2'd1;
      else if (d_exc[2]) m_cause = 2'd2;
    end
    @(posedge h_clk);
    #1;
  endtask

  initial begin
    idle();
    m_active = 0; m_elapsed = 0; m_redir = 0; m_ret = 0;
    m_mepc = '0; m_cause = '0; m_in_trap = 0;
    h_rst = 0;
    @(posedge h_clk);
    #1;
    cycle();                      // reset state
    h_rst = 1;
    cycle();

    // Load-use on rs1: one stall cycle
    ex_ce = 1; ex_load = 1; ex_rd = 5; d_ce = 1; d_rs1 = 5;
    #1 chk("lu_hit", {29'd0, stall_f, stall_d, flush_e}, 32'h7);
    cycle();
    idle(); cycle();
    // ex_rd = 0 never hazards
    ex_ce = 1; ex_load = 1; ex_rd = 0; d_ce = 1; d_rs1 = 0;
    #1 chk("lu_x0", {29'd0, stall_f, stall_d, flush_e}, 32'h0);
    cycle();
    // rs2 match but rs2 unused
    ex_rd = 5; d_rs1 = 1; d_rs2 = 5; d_use_rs2 = 0;
    #1 chk("lu_rs2_unused", 32'(stall_f), 32'h0);
    cycle();
    idle();

    // ECALL at 0x40
    d_ce = 1; d_pc = 32'h40; d_exc = 4'b0010;
    cycle(); idle();
    #1 chk("ecall_mepc", mepc, 32'h40);
    chk("ecall_cause", 32'(cause), 32'd1);
    cycle(); cycle();
    #1 chk("ecall_redir", {redirect, pc_target[30:0]}, {1'b1, 31'h4});
    cycle();
    #1 chk("ecall_in_trap", 32'(in_trap), 32'd1);
    cycle();

    // Branch beats exception in the same cycle
    ex_ce = 1; ex_redirect = 1; ex_target = 32'h100;
    d_ce = 1; d_pc = 32'h200; d_exc = 4'b0010;
    #1 chk("br_target", pc_target, 32'h100);
    cycle(); idle();
    #1 chk("br_mepc_kept", mepc, 32'h40);
    chk("br_no_drain", 32'(stall_f), 32'd0);
    cycle();

    // MRET while in_trap
    d_ce = 1; d_pc = 32'h300; d_exc = 4'b1000;
    cycle(); idle(); cycle(); cycle();
    #1 chk("mret_target", pc_target, 32'h40);
    cycle();
    #1 chk("mret_in_trap", 32'(in_trap), 32'd0);
    chk("mret_mepc", mepc, 32'h40);
    chk("mret_cause", 32'(cause), 32'd1);
    cycle();

    // ILLEGAL|EBREAK with mem busy held 5 cycles
    d_ce = 1; d_pc = 32'h80; d_exc = 4'b0101; mem_busy = 1;
    cycle(); idle(); mem_busy = 1;
    #1 chk("ill_cause", 32'(cause), 32'd0);
    for (int i = 0; i < 4; i++) cycle();
    mem_busy = 0;
    #1 chk("ill_no_redir_yet", 32'(redirect), 32'd0);
    cycle();
    #1 chk("ill_redir", pc_target, TV);
    cycle(); cycle();

    // Reset in the middle of DRAIN
    d_ce = 1; d_pc = 32'h500; d_exc = 4'b0100;
    cycle(); idle();
    h_rst = 0;
    cycle();
    h_rst = 1;
    #1 chk("rst_mepc", mepc, 32'h0);
    chk("rst_in_trap", 32'(in_trap), 32'd0);
    for (int i = 0; i < 4; i++) cycle();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      h_rst       = ($urandom_range(0, 199) != 0);
      d_ce        = $urandom_range(0, 3) != 0;
      d_pc        = {$urandom_range(0, 16'hffff), 2'b00};
      d_rs1       = AW'($urandom_range(0, 3));
      d_rs2       = AW'($urandom_range(0, 3));
      d_use_rs2   = $urandom_range(0, 1);
      d_exc       = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      ex_ce       = $urandom_range(0, 3) != 0;
      ex_load     = $urandom_range(0, 1);
      ex_rd       = AW'($urandom_range(0, 3));
      ex_redirect = ($urandom_range(0, 7) == 0);
      ex_target   = {$urandom_range(0, 16'hffff), 2'b00};
      mem_busy    = ($urandom_range(0, 5) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
